// File: rtl/hv_pwm_intb_encode.sv
// HV-side PWM INTB transmitter: turns interrupt level changes into
// pulse-count frames on an idle-high line (1 pulse = assert, 4 = release).
module hv_pwm_intb_encode #(
  parameter int PULSE_CYC = 5,
  parameter int GAP_CYC   = 3,
  parameter int GUARD_CYC = 12,
  parameter int CNT_W     = $clog2(((PULSE_CYC > GAP_CYC)
                                    ? ((PULSE_CYC > GUARD_CYC) ? PULSE_CYC : GUARD_CYC)
                                    : ((GAP_CYC > GUARD_CYC) ? GAP_CYC : GUARD_CYC)) + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_hv_intb_n,
  output logic o_hv_pwm_intb_n,
  output logic o_busy,
  output logic o_sent_intb_n
);

  // Timing values outside these windows would violate the LV decoder's
  // pulse-width / timeout limits, so refuse to elaborate quietly.
  generate
    if (PULSE_CYC < 5 || PULSE_CYC > 7) begin : g_bad_pulse
      $error("hv_pwm_intb_encode: PULSE_CYC=%0d outside 5..7", PULSE_CYC);
    end
    if (GAP_CYC < 2 || GAP_CYC > (8 - PULSE_CYC)) begin : g_bad_gap
      $error("hv_pwm_intb_encode: GAP_CYC=%0d outside 2..%0d", GAP_CYC, 8 - PULSE_CYC);
    end
    if (GUARD_CYC < 10) begin : g_bad_guard
      $error("hv_pwm_intb_encode: GUARD_CYC=%0d below 10", GUARD_CYC);
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, PULSE, GAP, GUARD} state_t;

  localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cyc_cnt_reg, cyc_cnt_next;
  logic [2:0]       pls_left_reg, pls_left_next;
  logic             line_reg, line_next;
  logic             busy_reg, busy_next;
  logic             sent_reg, sent_next;

  // State and output flops; reset forces the line high immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      cyc_cnt_reg  <= '0;
      pls_left_reg <= '0;
      line_reg     <= 1'b1;
      busy_reg     <= 1'b0;
      sent_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cyc_cnt_reg  <= cyc_cnt_next;
      pls_left_reg <= pls_left_next;
      line_reg     <= line_next;
      busy_reg     <= busy_next;
      sent_reg     <= sent_next;
    end
  end

  // Frame sequencing: each state holds for its cycle count, counter restarts at 1.
  always_comb begin
    state_next    = state_reg;
    cyc_cnt_next  = cyc_cnt_reg;
    pls_left_next = pls_left_reg;
    line_next     = line_reg;
    busy_next     = busy_reg;
    sent_next     = sent_reg;
    case (state_reg)
      IDLE: begin
        line_next    = 1'b1;
        busy_next    = 1'b0;
        cyc_cnt_next = '0;
        // Only the level seen here matters; toggles during a frame are coalesced.
        if (i_hv_intb_n != sent_reg) begin
          state_next    = PULSE;
          line_next     = 1'b0;
          cyc_cnt_next  = CNT_ONE;
          sent_next     = i_hv_intb_n;
          pls_left_next = i_hv_intb_n ? 3'd4 : 3'd1;
          busy_next     = 1'b1;
        end
      end
      PULSE: begin
        if (cyc_cnt_reg == PULSE_END) begin
          line_next    = 1'b1;
          cyc_cnt_next = CNT_ONE;
          if (pls_left_reg > 3'd1) begin
            state_next    = GAP;
            pls_left_next = pls_left_reg - 3'd1;
          end else begin
            state_next = GUARD;
          end
        end else begin
          cyc_cnt_next = cyc_cnt_reg + CNT_ONE;
        end
      end
      GAP: begin
        if (cyc_cnt_reg == GAP_END) begin
          state_next   = PULSE;
          line_next    = 1'b0;
          cyc_cnt_next = CNT_ONE;
        end else begin
          cyc_cnt_next = cyc_cnt_reg + CNT_ONE;
        end
      end
      GUARD: begin
        if (cyc_cnt_reg == GUARD_END) begin
          state_next   = IDLE;
          busy_next    = 1'b0;
          cyc_cnt_next = '0;
        end else begin
          cyc_cnt_next = cyc_cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next   = IDLE;
        line_next    = 1'b1;
        busy_next    = 1'b0;
        cyc_cnt_next = '0;
      end
    endcase
  end

  assign o_hv_pwm_intb_n = line_reg;
  assign o_busy          = busy_reg;
  assign o_sent_intb_n   = sent_reg;

endmodule

// File: tb/tb_hv_pwm_intb_encode.sv
// Bench for hv_pwm_intb_encode: directed level changes, expected frames
// queued by the stimulus and checked by an independent frame monitor.
module tb_hv_pwm_intb_encode;

  localparam int PULSE_CYC = 5;
  localparam int GAP_CYC   = 3;
  localparam int GUARD_CYC = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hv_intb_n = 1'b1;
  logic pwm_n, busy, sent_n;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic level;
    int   idle_before;  // -1: don't care
  } exp_t;
  exp_t exp_q[$];

  hv_pwm_intb_encode #(
    .PULSE_CYC(PULSE_CYC),
    .GAP_CYC  (GAP_CYC),
    .GUARD_CYC(GUARD_CYC)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_hv_intb_n    (hv_intb_n),
    .o_hv_pwm_intb_n(pwm_n),
    .o_busy         (busy),
    .o_sent_intb_n  (sent_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic lvl, input int idle);
    exp_q.push_back(exp_t'{level: lvl, idle_before: idle});
  endtask

  // Advance n falling edges, then step just past them to drive inputs.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Wait for three consecutive idle cycles, bounded.
  task automatic wait_idle(input string name);
    int quiet = 0;
    int spent = 0;
    while (quiet < 3 && spent < 200) begin
      @(negedge clk);
      spent++;
      quiet = busy ? 0 : quiet + 1;
    end
    #1;
    check(name, (quiet >= 3) ? 1 : 0, 1);
  endtask

  // Monitor: rebuilds each frame from the line and compares with the queue.
  initial begin : monitor
    bit   in_frame = 1'b0;
    int   npulse = 0, bad_w = 0, bad_g = 0, busy_cyc = 0;
    int   low_run = 0, high_run = 0, idle_run = 0, idle_at_start = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
        idle_run = 0;
      end else begin
        if (!in_frame && busy) begin
          in_frame = 1'b1;
          npulse = 0; bad_w = 0; bad_g = 0; busy_cyc = 0;
          low_run = 0; high_run = 0;
          idle_at_start = idle_run;
        end
        if (!in_frame) begin
          idle_run++;
        end else if (busy) begin
          busy_cyc++;
          if (!pwm_n) begin
            if (npulse > 0 && high_run > 0 && high_run != GAP_CYC) bad_g++;
            high_run = 0;
            low_run++;
          end else begin
            if (low_run > 0) begin
              npulse++;
              if (low_run != PULSE_CYC) bad_w++;
            end
            low_run = 0;
            high_run++;
          end
        end else begin
          in_frame = 1'b0;
          idle_run = 1;
          $display("frame: pulses=%0d busy=%0d guard=%0d sent=%0b", npulse, busy_cyc, high_run, sent_n);
          check("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_level", sent_n, e.level);
            check("frame_pulses", npulse, e.level ? 4 : 1);
            check("pulse_width_errs", bad_w, 0);
            check("gap_width_errs", bad_g, 0);
            check("guard_len", high_run, 12);
            check("busy_len", busy_cyc, e.level ? 41 : 17);
            check("line_high_at_idle", pwm_n, 1);
            if (e.idle_before >= 0) check("idle_before_frame", idle_at_start, e.idle_before);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    rst_n = 1'b0;
    hv_intb_n = 1'b1;
    cycles(3);
    check("rst_line", pwm_n, 1);
    check("rst_busy", busy, 0);
    check("rst_sent", sent_n, 1);
    rst_n = 1'b1;

    // Quiet after reset release
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      check("idle_after_reset", {pwm_n, busy, sent_n}, 3'b101);
    end

    // Assert: one pulse, one cycle after the sampling edge
    push_exp(1'b0, -1);
    hv_intb_n = 1'b0;
    @(posedge clk); #1;
    check("assert_latency_line", pwm_n, 0);
    check("assert_busy", busy, 1);
    check("assert_sent", sent_n, 0);
    wait_idle("assert_done");

    // Release: four pulses
    push_exp(1'b1, -1);
    hv_intb_n = 1'b1;
    @(posedge clk); #1;
    check("release_latency_line", pwm_n, 0);
    check("release_sent", sent_n, 1);
    wait_idle("release_done");

    // Assert, release 3 cycles later: assert frame then back-to-back release
    push_exp(1'b0, -1);
    push_exp(1'b1, 1);
    hv_intb_n = 1'b0;
    cycles(3);
    hv_intb_n = 1'b1;
    wait_idle("coalesce_pair_done");
    check("coalesce_pair_sent", sent_n, 1);

    // Assert/release/assert inside one frame: only one assert frame
    push_exp(1'b0, -1);
    hv_intb_n = 1'b0;
    cycles(2);
    hv_intb_n = 1'b1;
    cycles(2);
    hv_intb_n = 1'b0;
    wait_idle("coalesce_triple_done");
    cycles(20);
    check("coalesce_triple_quiet", {pwm_n, busy, sent_n}, 3'b100);

    // Return to released state
    push_exp(1'b1, -1);
    hv_intb_n = 1'b1;
    wait_idle("rerelease_done");

    // Reset on the third low cycle of an assert pulse
    hv_intb_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_pulse_low", pwm_n, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_line", pwm_n, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_sent", sent_n, 1);
    cycles(3);
    check("held_rst_state", {pwm_n, busy, sent_n}, 3'b101);
    push_exp(1'b0, -1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_frame_line", pwm_n, 0);
    check("post_rst_frame_sent", sent_n, 0);
    wait_idle("post_rst_done");

    cycles(5);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hv_pwm_intb_encode.md
Name: hv_pwm_intb_encode

Overview:
HV-side transmitter for the single-wire PWM INTB channel. It converts the HV interrupt level into a pulse-count frame on the active-low line toward the LV die.
- Interrupt assert (intb_n 1->0) is sent as 1 low pulse.
- Interrupt release (intb_n 0->1) is sent as 4 low pulses.
- Pulse widths, gaps and guard time fit the LV decoder's window: pulse width 4..8 cycles, inter-detection timeout >8 cycles.
- Level changes are coalesced, so the line always converges to the latest interrupt level.

Parameters:
PULSE_CYC, 5, low time of one pulse in i_clk cycles; legal range 5..7.
GAP_CYC, 3, high time between pulses of one frame; legal range 2..(8-PULSE_CYC).
GUARD_CYC, 12, minimum high time after a frame before the next frame; must be >=10.
CNT_W, $clog2(max(PULSE_CYC,GAP_CYC,GUARD_CYC)+1), width of the cycle counter.

Ports:
i_clk  input  1  block clock. Same clock domain as i_hv_intb_n.
i_rst_n  input  1  asynchronous active-low reset.
i_hv_intb_n  input  1  HV interrupt level, active low, synchronous to i_clk.
o_hv_pwm_intb_n  output  1  encoded line. Idle high, pulses low. Driven directly from a flop.
o_busy  output  1  high while a frame or its guard time is in progress.
o_sent_intb_n  output  1  level carried by the most recently started frame.

Behaviour:
- Reset values: o_hv_pwm_intb_n=1, o_busy=0, o_sent_intb_n=1, FSM=IDLE, counters=0.
- Reset takes effect asynchronously at any point, including mid-pulse; the line returns high immediately.
- FSM states: IDLE, PULSE, GAP, GUARD. Registers:
  - cyc_cnt, CNT_W bits.
  - pls_left, 3 bits.
- IDLE:
  - If i_hv_intb_n != o_sent_intb_n at edge T, then at T+1:
    - enter PULSE, o_hv_pwm_intb_n=0, cyc_cnt=1;
    - o_sent_intb_n <= i_hv_intb_n;
    - pls_left = 1 if the new level is 0, else 4;
    - o_busy=1.
  - Latency from input change to line falling edge: 1 cycle.
- PULSE: the line stays low for exactly PULSE_CYC cycles. On the last cycle:
  - if pls_left>1: go to GAP, line high, pls_left-1;
  - else: go to GUARD, line high.
- GAP: the line stays high for exactly GAP_CYC cycles, then returns to PULSE (line low).
- GUARD: the line stays high for exactly GUARD_CYC cycles, then goes to IDLE; o_busy=0 in IDLE.
- Back-to-back frames:
  - A mismatch present on the first IDLE cycle starts the next frame on the following cycle.
  - The minimum high time between frames is therefore GUARD_CYC+1.
- Frame lengths (first low cycle through last low cycle):
  - assert frame: PULSE_CYC;
  - release frame: 4*PULSE_CYC + 3*GAP_CYC (29 cycles at defaults).
- Changes of i_hv_intb_n during PULSE/GAP/GUARD are ignored while the frame runs. Only the level sampled in IDLE matters:
  - intermediate toggles are dropped;
  - the final level is always sent if it differs from o_sent_intb_n.
- A frame in progress is never aborted or truncated except by reset.
- Counter arithmetic: cyc_cnt resets to 1 on each state entry and increments to the parameter value. No wrap occurs within legal parameter ranges.
- Out-of-range parameters are a configuration error; simulation flags them with an elaboration-time $error.

Test Plan:
- Reset release with i_hv_intb_n=1 for 50 cycles -> line stays 1, o_busy=0, o_sent_intb_n=1.
- i_hv_intb_n 1->0 at edge T -> line low for cycles T+1..T+5, high thereafter; o_busy high T+1..T+17; o_sent_intb_n=0 from T+1.
- i_hv_intb_n 0->1 from the asserted state -> four 5-cycle low pulses separated by 3-cycle highs (29 cycles), then 12-cycle guard. Loopback into lv_pwm_intb_decode yields o_hv_intb_n rising once.
- Assert then release 3 cycles later (inside the assert frame) -> assert frame completes, then after guard+1 a 4-pulse release frame is sent. Decoder output goes 1->0->1.
- Assert, then release, then assert again, all inside one frame -> only the single assert frame is sent; no second frame follows because the level matches o_sent_intb_n.
- Assert i_rst_n low on the 3rd low cycle of a pulse -> line 1 in the same cycle, o_busy=0, o_sent_intb_n=1. After release, a held i_hv_intb_n=0 triggers a fresh 1-pulse frame.
